rca_word_sequencer: RTL and testbench

Multi-cycle wide add/subtract controller that sequences one shared 8-bit ripple-carry adder (RCA_8b) over NUM_BYTES byte slices, least-significant byte first, and registers the carry between slices. It accepts one operation per start pulse, reports busy, and pulses done when the full-width result is committed. It sits between the ALU control logic and the RCA_8b datapath, giving 32-bit arithmetic at one adder's area cost.

---
 rtl/rca_seq_pkg.sv | 9 +
 rtl/rca_word_sequencer_rca8.sv | 18 +
 rtl/rca_word_sequencer.sv | 88 ++++++++
 tb/tb_rca_word_sequencer.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/rca_seq_pkg.sv
// rca_seq_pkg: shared slice width and sequencer state encoding
package rca_seq_pkg;
  localparam int SLICE_W = 8;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;
endpackage

// File: rtl/rca_word_sequencer_rca8.sv
// RCA_8b: 8-bit ripple-carry adder built from a chain of full adders
module RCA_8b
  import rca_seq_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               c_in,
  output logic [SLICE_W-1:0] sum,
  output logic               c_out
);
  logic [SLICE_W:0] c;
  assign c[0] = c_in;
  for (genvar i = 0; i < SLICE_W; i++) begin : g_fa
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end
  assign c_out = c[SLICE_W];
endmodule

// File: rtl/rca_word_sequencer.sv
// rca_word_sequencer: wide add/subtract by sequencing one RCA_8b over byte slices, LSB first
module rca_word_sequencer
  import rca_seq_pkg::*;
#(
  parameter int NUM_BYTES = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         sub,
  input  logic                         c_in,
  input  logic [SLICE_W*NUM_BYTES-1:0] a,
  input  logic [SLICE_W*NUM_BYTES-1:0] b,
  output logic                         busy,
  output logic                         done,
  output logic [SLICE_W*NUM_BYTES-1:0] sum,
  output logic                         c_out,
  output logic                         overflow
);
  localparam int W  = SLICE_W * NUM_BYTES;
  localparam int IW = $clog2(NUM_BYTES);
  localparam logic [IW-1:0] LAST = IW'(NUM_BYTES - 1);
  state_t               state;
  logic [IW-1:0]        idx;
  logic                 carry;
  logic [W-1:0]         a_r, b_r, work, nxt;
  logic [SLICE_W-1:0]   sa, sb, ss;
  logic                 sc;
  assign sa = a_r[idx*SLICE_W +: SLICE_W];
  assign sb = b_r[idx*SLICE_W +: SLICE_W];
  RCA_8b u_rca (
    .a    (sa),
    .b    (sb),
    .c_in (carry),
    .sum  (ss),
    .c_out(sc)
  );
  // Working word with the current slice result merged in, so the last slice reaches sum on the same edge
  always_comb begin
    nxt = work;
    nxt[idx*SLICE_W +: SLICE_W] = ss;
  end
  // Sequencer: latch operands (b inverted with carry-in 1 for subtract), step slices, commit on the last one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      idx      <= '0;
      carry    <= 1'b0;
      a_r      <= '0;
      b_r      <= '0;
      work     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      sum      <= '0;
      c_out    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (start) begin
          a_r   <= a;
          b_r   <= sub ? ~b : b;
          carry <= sub ? 1'b1 : c_in;
          idx   <= '0;
          busy  <= 1'b1;
          state <= ST_RUN;
        end
        ST_RUN: begin
          work  <= nxt;
          carry <= sc;
          idx   <= idx + 1'b1;
          if (idx == LAST) begin
            state    <= ST_DONE;
            done     <= 1'b1;
            sum      <= nxt;
            c_out    <= sc;
            overflow <= (a_r[W-1] == b_r[W-1]) && (nxt[W-1] != a_r[W-1]);
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rca_word_sequencer.sv
// tb_rca_word_sequencer: directed self-checking bench for the 32-bit byte-serial adder
module tb_rca_word_sequencer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        sub = 1'b0;
  logic        c_in = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy, done, c_out, overflow;
  logic [31:0] sum;
  int checks = 0;
  int failures = 0;

  rca_word_sequencer #(.NUM_BYTES(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .c_in(c_in),
    .a(a), .b(b), .busy(busy), .done(done), .sum(sum), .c_out(c_out), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch one operation, require done exactly 4 edges after the accept edge, check results
  task automatic run_op(input string name, input logic [31:0] ta, input logic [31:0] tb_, input logic ts,
                        input logic tc, input logic [31:0] es, input logic ec, input logic eo);
    int n;
    a = ta; b = tb_; sub = ts; c_in = tc; start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL %s busy_after_accept got=%b want=1", name, busy); end
    n = 0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (done === 1'b1) begin n = i; break; end
    end
    checks++;
    if (n != 4) begin failures++; $display("FAIL %s done_latency got=%0d want=4", name, n); end
    checks++;
    if (sum !== es) begin failures++; $display("FAIL %s sum got=%h want=%h", name, sum, es); end
    checks++;
    if (c_out !== ec) begin failures++; $display("FAIL %s c_out got=%b want=%b", name, c_out, ec); end
    checks++;
    if (overflow !== eo) begin failures++; $display("FAIL %s overflow got=%b want=%b", name, overflow, eo); end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL %s after_done done=%b busy=%b want=0,0", name, done, busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if ({busy, done, c_out, overflow} !== 4'b0 || sum !== 32'h0) begin
      failures++; $display("FAIL reset got busy=%b done=%b sum=%h c_out=%b ov=%b want all 0", busy, done, sum, c_out, overflow);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL idle_busy got=%b want=0", busy); end
  endtask

  task automatic test_add();
    run_op("carry_chain", 32'h000000FF, 32'h00000001, 1'b0, 1'b0, 32'h00000100, 1'b0, 1'b0);
    run_op("full_wrap",   32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0);
    run_op("signed_ovf",  32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1);
  endtask

  task automatic test_sub();
    run_op("sub_borrow",    32'h00000005, 32'h00000007, 1'b1, 1'b0, 32'hFFFFFFFE, 1'b0, 1'b0);
    run_op("sub_no_borrow", 32'h00000007, 32'h00000005, 1'b1, 1'b1, 32'h00000002, 1'b1, 1'b0);
  endtask

  task automatic test_reset_mid_run();
    int seen;
    a = 32'h12345678; b = 32'h11111111; sub = 1'b0; c_in = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (sum !== 32'h00000002) begin failures++; $display("FAIL held_sum_in_run got=%h want=00000002", sum); end
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || sum !== 32'h0 || c_out !== 1'b0) begin
      failures++; $display("FAIL async_reset got busy=%b done=%b sum=%h c_out=%b want 0", busy, done, sum, c_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done === 1'b1 || busy === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin failures++; $display("FAIL no_done_after_abort got=%0d active cycles want=0", seen); end
  endtask

  task automatic test_start_busy();
    int n;
    a = 32'h000000FF; b = 32'h00000001; sub = 1'b0; c_in = 1'b0; start = 1'b1;
    tick();
    a = 32'hAAAAAAAA; b = 32'h55555555; sub = 1'b1; c_in = 1'b1;
    tick();
    tick();
    start = 1'b0;
    n = 0;
    for (int i = 1; i <= 10; i++) begin
      if (done === 1'b1) begin n = i; break; end
      tick();
    end
    checks++;
    if (n == 0) begin failures++; $display("FAIL busy_start_done got=timeout want=done"); end
    checks++;
    if (sum !== 32'h00000100) begin failures++; $display("FAIL busy_start_sum got=%h want=00000100", sum); end
    tick();
    run_op("back_to_back", 32'h00010000, 32'h0000FFFF, 1'b0, 1'b1, 32'h00020000, 1'b0, 1'b0);
    tick();
    checks++;
    if (sum !== 32'h00020000) begin failures++; $display("FAIL held_sum_idle got=%h want=00020000", sum); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_reset_mid_run();
    test_start_busy();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
endmodule
